led_scan: RTL and testbench



---
 rtl/led_scan_pkg.sv | 33 +++
 rtl/btn_edge.sv | 41 ++++
 rtl/led_scan.sv | 203 ++++++++++++++++++++
 tb/tb_led_scan.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared definitions for the LED matrix scanner: matrix geometry, scan
// state and page encodings, and helpers for row selection and word extraction.
package led_scan_pkg;

    localparam int NROWS = 8;
    localparam int NCOLS = 16;
    localparam int ROW_W = $clog2(NROWS);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    typedef enum logic {
        PAGE_REG  = 1'b0,
        PAGE_MISC = 1'b1
    } page_t;

    // One-hot row drive pattern for a row index.
    function automatic logic [NROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
        logic [NROWS-1:0] oh;
        oh      = {NROWS{1'b0}};
        oh[row] = 1'b1;
        return oh;
    endfunction

    // Word idx of a packed 8 x 16 page (word i = bits [16i+15:16i]).
    function automatic logic [NCOLS-1:0] page_word(input logic [NROWS*NCOLS-1:0] bus,
                                                   input logic [ROW_W-1:0] idx);
        return bus[{idx, 4'b0000} +: NCOLS];
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Multi-stage synchronizer for an asynchronous push button followed by a
// rising-edge detector that emits a registered one-cycle pulse.
module btn_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   pulse_r;

    // Shift the raw button level through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r[0] <= btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Detect a 0->1 transition of the synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            prev_r  <= sync_r[SYNC_STAGES-1];
            pulse_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/led_scan.sv
// LED matrix scanner: shows one 8 x 16 page (register or misc) row by row.
// Each row slot is PRESCALE cycles: BLANK cycles dark, then the row is lit.
// The page is snapshotted at every frame boundary so a frame never tears.
// Optional feature macro LED_SCAN_DIM_EN adds a 3-bit brightness input that
// shortens the lit window in steps of (PRESCALE-BLANK)/8 cycles.
module led_scan
    import led_scan_pkg::*;
#(
    parameter int PRESCALE    = 18,
    parameter int BLANK       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [NROWS*NCOLS-1:0] led_reg,
    input  logic [NROWS*NCOLS-1:0] led_misc,
    input  logic [3:0]             led_ph,
    input  logic                   page_btn,
`ifdef LED_SCAN_DIM_EN
    input  logic [2:0]             brightness,
`endif
    output logic [NROWS-1:0]       led_row,
    output logic [NCOLS-1:0]       led_col,
    output logic                   led_page,
    output logic [3:0]             led_phase,
    output logic                   frame_start
);

    localparam int                 CNT_W     = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]   CNT_BLEND = CNT_W'(BLANK - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(NROWS - 1);

    logic [CNT_W-1:0]       cnt_r;
    logic [ROW_W-1:0]       row_r;
    scan_state_t            state_r;
    scan_state_t            state_nxt_s;
    logic                   page_req_r;
    page_t                  page_r;
    logic [NROWS*NCOLS-1:0] snap_r;
    logic [NROWS-1:0]       led_row_r;
    logic [NCOLS-1:0]       led_col_r;
    logic [3:0]             led_phase_r;
    logic                   frame_start_r;
    logic                   btn_pulse_s;
    logic                   slot_end_s;
    logic                   frame_end_s;
    logic                   lit_s;
    logic [NROWS-1:0]       row_drive_s;
    logic [NCOLS-1:0]       col_drive_s;

    assign slot_end_s  = (cnt_r == CNT_LAST);
    assign frame_end_s = slot_end_s && (row_r == ROW_LAST);

    btn_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn_edge (
        .clk   (CLK),
        .rst_n (RSTN),
        .btn   (page_btn),
        .pulse (btn_pulse_s)
    );

`ifdef LED_SCAN_DIM_EN
    localparam int DIM_UNIT = (PRESCALE - BLANK) / 8;

    logic [2:0]  bright_r;
    logic [31:0] show_off_s;
    logic [31:0] lit_lim_s;

    // Latch brightness once per slot so a mid-slot change waits for the next row.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            bright_r <= 3'd0;
        end else if (cnt_r == CNT_ZERO) begin
            bright_r <= brightness;
        end else begin
            bright_r <= bright_r;
        end
    end

    // Lit while the offset into SHOW is below the brightness-scaled window.
    always_comb begin
        show_off_s = 32'(cnt_r) - 32'(BLANK);
        lit_lim_s  = 32'(DIM_UNIT) * (32'(bright_r) + 32'd1);
        lit_s      = (show_off_s < lit_lim_s);
    end
`else
    assign lit_s = 1'b1;
`endif

    // Slot counter and row index; row advances when the slot wraps.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_r <= CNT_ZERO;
            row_r <= {ROW_W{1'b0}};
        end else if (slot_end_s) begin
            cnt_r <= CNT_ZERO;
            row_r <= row_r + 3'd1;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
            row_r <= row_r;
        end
    end

    // Scan state register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= ST_BLANK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next scan state: enter SHOW as cnt reaches BLANK, return to BLANK at slot wrap.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == CNT_BLEND) begin
                    state_nxt_s = ST_SHOW;
                end else begin
                    state_nxt_s = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (slot_end_s) begin
                    state_nxt_s = ST_BLANK;
                end else begin
                    state_nxt_s = ST_SHOW;
                end
            end
            default: state_nxt_s = ST_BLANK;
        endcase
    end

    // Row/column drive for the current cycle; dark unless SHOW and within the lit window.
    always_comb begin
        row_drive_s = {NROWS{1'b0}};
        col_drive_s = {NCOLS{1'b0}};
        if ((state_r == ST_SHOW) && lit_s) begin
            row_drive_s = row_onehot(row_r);
            col_drive_s = page_word(snap_r, row_r);
        end else begin
            row_drive_s = {NROWS{1'b0}};
            col_drive_s = {NCOLS{1'b0}};
        end
    end

    // Register the matrix drive so outputs are glitch-free.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            led_row_r <= {NROWS{1'b0}};
            led_col_r <= {NCOLS{1'b0}};
        end else begin
            led_row_r <= row_drive_s;
            led_col_r <= col_drive_s;
        end
    end

    // Each synchronized button press toggles the requested page.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            page_req_r <= 1'b0;
        end else begin
            page_req_r <= page_req_r ^ btn_pulse_s;
        end
    end

    // At the frame boundary capture the requested page and its contents.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            snap_r <= {(NROWS*NCOLS){1'b0}};
            page_r <= PAGE_REG;
        end else if (frame_end_s) begin
            snap_r <= page_req_r ? led_misc : led_reg;
            page_r <= page_req_r ? PAGE_MISC : PAGE_REG;
        end else begin
            snap_r <= snap_r;
            page_r <= page_r;
        end
    end

    // Frame-start pulse and registered phase copy.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            frame_start_r <= 1'b0;
            led_phase_r   <= 4'd0;
        end else begin
            frame_start_r <= frame_end_s;
            led_phase_r   <= led_ph;
        end
    end

    assign led_row     = led_row_r;
    assign led_col     = led_col_r;
    assign led_page    = page_r;
    assign led_phase   = led_phase_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_led_scan.sv
// Scoreboard bench for led_scan: the stimulus process pushes expected row
// bursts and frame_start cycles; a monitor measures bursts on the outputs
// and compares them against the queued expectations.
module tb_led_scan;

    logic         CLK;
    logic         RSTN;
    logic [127:0] led_reg;
    logic [127:0] led_misc;
    logic [3:0]   led_ph;
    logic         page_btn;
    logic [7:0]   led_row;
    logic [15:0]  led_col;
    logic         led_page;
    logic [3:0]   led_phase;
    logic         frame_start;
`ifdef LED_SCAN_DIM_EN
    logic [2:0]   brightness;
    initial brightness = 3'd7;
`endif

    led_scan #(.PRESCALE(18), .BLANK(2), .SYNC_STAGES(2)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .led_reg     (led_reg),
        .led_misc    (led_misc),
        .led_ph      (led_ph),
        .page_btn    (page_btn),
`ifdef LED_SCAN_DIM_EN
        .brightness  (brightness),
`endif
        .led_row     (led_row),
        .led_col     (led_col),
        .led_page    (led_page),
        .led_phase   (led_phase),
        .frame_start (frame_start)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  row;
        logic [15:0] col;
        int          len;
        logic        page;
        int          start;
    } burst_t;

    burst_t      exp_q[$];
    int          fs_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          leak  = 0;
    logic [15:0] zero_w[8];
    logic [15:0] reg_a[8];
    logic [15:0] reg_b[8];
    logic [15:0] misc_w[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // sel: 0 zeros, 1 reg page before word5 change, 2 reg page after, 3 misc page
    task automatic push_frame(input int f, input int sel, input logic page, input int nrows);
        burst_t b;
        for (int r = 0; r < nrows; r++) begin
            b.row   = 8'h01 << r;
            case (sel)
                0:       b.col = zero_w[r];
                1:       b.col = reg_a[r];
                2:       b.col = reg_b[r];
                default: b.col = misc_w[r];
            endcase
            b.len   = 16;
            b.page  = page;
            b.start = 144 * f + 18 * r + 3;
            exp_q.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic release_rst();
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        cyc  = 0;
    endtask

    // ---------------- monitor ----------------
    int          mon_cyc  = -1;
    logic        in_burst = 1'b0;
    logic [7:0]  b_row;
    logic [15:0] b_col;
    int          b_len;
    logic        b_page;
    int          b_start;
    logic        b_bad;

    task automatic finish_burst();
        burst_t e;
        in_burst = 1'b0;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL burst_extra: got row %h col %h len %0d at %0d, none expected",
                     b_row, b_col, b_len, b_start);
        end else begin
            e = exp_q.pop_front();
            chk("burst {unstable,page,row,col,len,start}",
                {8'h00, 3'b000, b_bad, 3'b000, b_page, b_row, b_col, 8'(b_len), 16'(b_start)},
                {8'h00, 4'h0, 3'b000, e.page, e.row, e.col, 8'(e.len), 16'(e.start)});
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (!RSTN) begin
                if (in_burst) finish_burst();
                mon_cyc = -1;
            end else begin
                mon_cyc++;
                if (frame_start) begin
                    if (fs_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL frame_start_extra: pulse at %0d, none expected", mon_cyc);
                    end else begin
                        chk("frame_start_cycle", 64'(mon_cyc), 64'(fs_q.pop_front()));
                    end
                end
                if (led_row == 8'h00) begin
                    if (led_col != 16'h0000) leak++;
                    if (in_burst) finish_burst();
                end else if (in_burst && (led_row == b_row)) begin
                    b_len++;
                    if (led_col != b_col) b_bad = 1'b1;
                end else begin
                    if (in_burst) finish_burst();
                    in_burst = 1'b1;
                    b_row    = led_row;
                    b_col    = led_col;
                    b_len    = 1;
                    b_page   = led_page;
                    b_start  = mon_cyc;
                    b_bad    = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        zero_w = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        reg_a  = '{16'h1234, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0005, 16'h6666, 16'hBEEF};
        reg_b  = '{16'h1234, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hFFFF, 16'h6666, 16'hBEEF};
        misc_w = '{16'hC000, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005, 16'hC006, 16'hC007};

        RSTN     = 1'b0;
        page_btn = 1'b0;
        led_ph   = 4'hA;
        led_reg  = {16'hBEEF, 16'h6666, 16'h0005, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h1234};
        led_misc = {16'hC007, 16'hC006, 16'hC005, 16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_led_row",     64'(led_row),     64'h0);
        chk("reset_led_col",     64'(led_col),     64'h0);
        chk("reset_led_page",    64'(led_page),    64'h0);
        chk("reset_frame_start", 64'(frame_start), 64'h0);
        chk("reset_led_phase",   64'(led_phase),   64'h0);

        release_rst();
        push_frame(0, 0, 1'b0, 8);   // first frame after reset shows zeros
        push_frame(1, 1, 1'b0, 8);   // reg page, word5 change not yet visible
        push_frame(2, 3, 1'b1, 8);   // single toggle -> misc page
        push_frame(3, 3, 1'b1, 8);   // double toggle -> page unchanged
        push_frame(4, 2, 1'b0, 5);   // back to reg page with word5 = FFFF
        begin
            burst_t p;
            p.row = 8'h20; p.col = 16'hFFFF; p.len = 5; p.page = 1'b0; p.start = 669;
            exp_q.push_back(p);      // row 5 cut short by reset
        end
        fs_q.push_back(144);
        fs_q.push_back(288);
        fs_q.push_back(432);
        fs_q.push_back(576);

        go_to(10);
        led_ph = 4'h5;
        go_to(11);
        chk("led_phase_follow", 64'(led_phase), 64'h5);

        go_to(185);                        // frame 1, row 2
        led_reg[95:80] = 16'hFFFF;
        go_to(201);                        // frame 1, row 3
        page_btn = 1'b1;
        go_to(205);
        page_btn = 1'b0;
        go_to(345);                        // frame 2, row 3: two presses
        page_btn = 1'b1;
        go_to(349);
        page_btn = 1'b0;
        go_to(353);
        page_btn = 1'b1;
        go_to(357);
        page_btn = 1'b0;
        go_to(489);                        // frame 3, row 3: one press
        page_btn = 1'b1;
        go_to(493);
        page_btn = 1'b0;

        go_to(674);                        // frame 4, row 5 mid-SHOW
        chk("row5_driving", 64'(led_row), 64'h20);
        RSTN = 1'b0;
        #1;
        chk("midreset_led_row",     64'(led_row),     64'h0);
        chk("midreset_led_col",     64'(led_col),     64'h0);
        chk("midreset_frame_start", 64'(frame_start), 64'h0);
        repeat (2) @(posedge CLK);

        release_rst();
        push_frame(0, 0, 1'b0, 8);
        push_frame(1, 2, 1'b0, 8);
        fs_q.push_back(144);
        fs_q.push_back(288);
        go_to(300);
        #2;

        chk("bursts_missing",      64'(exp_q.size()), 64'h0);
        chk("frame_start_missing", 64'(fs_q.size()),  64'h0);
        chk("col_during_dark",     64'(leak),         64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
